hs4_tx_ctrl: RTL

Source-side controller for a four-phase (return-to-zero) req/ack handshake toward another clock domain.
- Accepts a word via valid/ready in the local domain and holds it stable on o_data.
- Drives o_req and brings the asynchronous i_ack back through an internal SYNC_STAGES flop chain.
- Sequences the full req-up / ack-up / req-down / ack-down cycle.
- Sits between local producer logic and a CDC data bus; the destination samples o_data on its own synchronized req.

---
 rtl/hs4_tx_ctrl_if.sv | 24 ++
 rtl/hs4_tx_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hs4_tx_ctrl_if.sv
// Handshake bundle for hs4_tx_ctrl: local valid/ready word input plus the
// req/data/ack bus toward the destination clock domain.
interface hs4_tx_ctrl_if #(
   parameter int DW = 8
);
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          o_ready;
   logic          o_req;
   logic [DW-1:0] o_data;
   logic          i_ack;

   // Controller side
   modport slave (
      input  i_valid, i_data, i_ack,
      output o_ready, o_req, o_data
   );

   // Producer / destination side
   modport master (
      output i_valid, i_data, i_ack,
      input  o_ready, o_req, o_data
   );
endinterface

// File: rtl/hs4_tx_ctrl.sv
// Source side of a four-phase req/ack handshake into another clock domain.
// Optional per-phase timeout with sticky error: define HS4_TX_TIMEOUT_EN.
module hs4_tx_ctrl #(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int TO_CYCLES   = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   hs4_tx_ctrl_if.slave     bus,
   output logic             o_done,
   output logic [CNT_W-1:0] o_count,
   output logic             o_err,
   input  logic             i_err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   req_q, req_d;
   logic [DW-1:0]          data_q, data_d;
   logic                   done_q, done_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   ack_s;
   logic                   ready_s;

`ifdef HS4_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   logic [TO_W-1:0] phase_q, phase_d;
   logic            err_q, err_d;
   logic            err_set_s;
`else
   logic unused_s;
   assign unused_s = i_err_clr ^ (TO_CYCLES == 0);
`endif

   assign ack_s   = sync_q[SYNC_STAGES-1];
   // A stale ack left over from an aborted transfer blocks new words.
   assign ready_s = (state_q == ST_IDLE) && !ack_s;

   // Next-state and next-output computation for the handshake sequencer
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.i_ack};
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      count_d = count_q;
`ifdef HS4_TX_TIMEOUT_EN
      phase_d   = phase_q;
      err_set_s = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.i_valid && ready_s) begin
               data_d  = bus.i_data;
               req_d   = 1'b1;
               state_d = ST_REQ;
`ifdef HS4_TX_TIMEOUT_EN
               phase_d = '0;
`endif
            end else begin
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ST_RELEASE;
`ifdef HS4_TX_TIMEOUT_EN
               phase_d = '0;
            end else if (phase_q == TO_LAST) begin
               req_d     = 1'b0;
               err_set_s = 1'b1;
               state_d   = ST_ERROR;
            end else begin
               req_d   = 1'b1;
               phase_d = phase_q + TO_W'(1);
            end
`else
            end else begin
               req_d = 1'b1;
            end
`endif
         end
         ST_RELEASE: begin
            req_d = 1'b0;
            if (!ack_s) begin
               done_d  = 1'b1;
               count_d = count_q + CNT_W'(1);
               state_d = ST_IDLE;
`ifdef HS4_TX_TIMEOUT_EN
            end else if (phase_q == TO_LAST) begin
               err_set_s = 1'b1;
               state_d   = ST_ERROR;
            end else begin
               phase_d = phase_q + TO_W'(1);
            end
`else
            end else begin
               state_d = ST_RELEASE;
            end
`endif
         end
         ST_ERROR: begin
            req_d = 1'b0;
`ifdef HS4_TX_TIMEOUT_EN
            if (i_err_clr) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ERROR;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
`ifdef HS4_TX_TIMEOUT_EN
      // A new timeout wins over a simultaneous clear so the error is never lost.
      err_d = err_set_s ? 1'b1 : (i_err_clr ? 1'b0 : err_q);
`endif
   end

   // State, synchronizer and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         sync_q  <= '0;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         count_q <= '0;
`ifdef HS4_TX_TIMEOUT_EN
         phase_q <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
         count_q <= count_d;
`ifdef HS4_TX_TIMEOUT_EN
         phase_q <= phase_d;
         err_q   <= err_d;
`endif
      end
   end

   assign bus.o_ready = ready_s;
   assign bus.o_req   = req_q;
   assign bus.o_data  = data_q;
   assign o_done      = done_q;
   assign o_count     = count_q;
`ifdef HS4_TX_TIMEOUT_EN
   assign o_err       = err_q;
`else
   assign o_err       = 1'b0;
`endif

endmodule
